// File: rtl/fifo_rd.sv
// Read-side companion to the ip_fifo pattern writer. It waits for almost_full, drains the FIFO
// in one burst, and checks the returned words against the writer's 0..MAX_VAL counting pattern.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | FIFO read side still in reset; no reads issued
// S_WAIT_FULL| armed; waiting for synchronized almost_full with data present
// S_READ     | burst in progress; fifo_rd_en held high until the FIFO drains
module fifo_rd #(
  parameter int DATA_W     = 8,
  parameter int MAX_VAL    = 254,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              rd_rst_busy,
  input  logic              empty,
  input  logic              almost_empty,
  input  logic              almost_full,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  burst_cnt
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FULL = 2'd1,
    S_READ      = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              fifo_rd_en_nxt;
  logic              burst_start;
  logic              burst_done;
  logic              af_d0;
  logic              af_d1;
  logic              issued;
  logic              lat_vld;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] expected_nxt;

  // almost_full comes from the write clock domain
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      af_d0 <= 1'b0;
      af_d1 <= 1'b0;
    end else begin
      af_d0 <= almost_full;
      af_d1 <= af_d0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_rd_en <= fifo_rd_en_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    burst_start = 1'b0;
    burst_done  = 1'b0;
    if (rd_rst_busy) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT_FULL;
        S_WAIT_FULL: begin
          if (af_d1 && !empty) begin
            state_nxt   = S_READ;
            burst_start = 1'b1;
          end
        end
        S_READ: begin
          // almost_empty with an active read means this cycle takes the last word
          if ((almost_empty && fifo_rd_en) || empty) begin
            state_nxt  = S_WAIT_FULL;
            burst_done = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_rd_en_nxt = (state_nxt == S_READ);
  end

  assign issued = fifo_rd_en && !empty;

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign lat_vld = issued;
    end else if (RD_LATENCY == 1) begin : g_lat1
      logic pipe;
      always_ff @(posedge rd_clk) begin
        if (rst) pipe <= 1'b0;
        else     pipe <= issued;
      end
      assign lat_vld = pipe;
    end else begin : g_latn
      logic [RD_LATENCY-1:0] pipe;
      always_ff @(posedge rd_clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[RD_LATENCY-2:0], issued};
      end
      assign lat_vld = pipe[RD_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= lat_vld;
      if (lat_vld) rd_data <= fifo_rd_data;
    end
  end

  // Resync to the received word so a single corrupted word is counted once
  always_comb begin
    expected_nxt = (fifo_rd_data >= MAX_V) ? '0 : fifo_rd_data + DATA_W'(1);
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      expected <= '0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (lat_vld && (fifo_rd_data != expected)) begin
        err_flag <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
      end
      // The writer restarts at 0 after the FIFO has emptied
      if (burst_start)  expected <= '0;
      else if (lat_vld) expected <= expected_nxt;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst)             burst_cnt <= '0;
    else if (burst_done) burst_cnt <= burst_cnt + CNT_W'(1);
  end

endmodule
